// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command sequencer driving an 8-bit ALU for ADD/SUB/MUL/DIV
// Optional op_cnt output is enabled with `define ALU_SEQ_CNT_EN.
module alu_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_a,
   input  logic [7:0] cmd_b,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_lo,
   output logic [7:0] res_hi,
   output logic       res_zero,
   output logic       res_err,
   output logic [2:0] alu_opt,
   output logic [7:0] alu_numa,
   output logic [7:0] alu_numb,
   output logic [7:0] alu_ci,
   input  logic [7:0] alu_s,
   input  logic       alu_zero,
   input  logic       alu_co
`ifdef ALU_SEQ_CNT_EN
   ,
   output logic [15:0] op_cnt
`endif
);

   localparam logic [2:0] OPT_NOP = 3'd0;
   localparam logic [2:0] OPT_ADD = 3'd1;
   localparam logic [2:0] OPT_SUB = 3'd2;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

   typedef enum logic [2:0] {IDLE, EXEC, MUL_LOOP, DIV_LOOP, DONE} state_t;

   state_t     state_q, state_d;
   logic [1:0] op_q, op_d;
   logic [7:0] a_q, a_d, b_q, b_d;
   logic [7:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
   logic       res_zero_q, res_zero_d, res_err_q, res_err_d;
   logic [7:0] nxt_hi, nxt_lo;
   logic       div_ok;
`ifdef ALU_SEQ_CNT_EN
   logic [15:0] op_cnt_q, op_cnt_d;
`endif

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      acc_hi_d   = acc_hi_q;
      acc_lo_d   = acc_lo_q;
      cnt_d      = cnt_q;
      res_lo_d   = res_lo_q;
      res_hi_d   = res_hi_q;
      res_zero_d = res_zero_q;
      res_err_d  = res_err_q;
      nxt_hi     = 8'd0;
      nxt_lo     = 8'd0;
      div_ok     = 1'b0;
      alu_opt    = OPT_NOP;
      alu_numa   = 8'd0;
      alu_numb   = 8'd0;
      cmd_ready  = 1'b0;
      res_valid  = 1'b0;
`ifdef ALU_SEQ_CNT_EN
      op_cnt_d   = op_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            cmd_ready = ~rst;
            if (cmd_valid) begin
               op_d  = cmd_op;
               a_d   = cmd_a;
               b_d   = cmd_b;
               cnt_d = 3'd0;
               case (cmd_op)
                  OP_MUL: begin
                     acc_hi_d = 8'd0;
                     acc_lo_d = cmd_b;
                     state_d  = MUL_LOOP;
                  end
                  OP_DIV: begin
                     acc_hi_d = 8'd0;
                     acc_lo_d = cmd_a;
                     state_d  = (cmd_b == 8'd0) ? EXEC : DIV_LOOP;
                  end
                  default: state_d = EXEC;
               endcase
            end
         end
         EXEC: begin
            if (op_q == OP_DIV) begin
               res_lo_d   = 8'hFF;
               res_hi_d   = a_q;
               res_zero_d = 1'b0;
               res_err_d  = 1'b1;
            end else begin
               alu_opt    = (op_q == OP_SUB) ? OPT_SUB : OPT_ADD;
               alu_numa   = a_q;
               alu_numb   = b_q;
               res_lo_d   = alu_s;
               res_hi_d   = {7'd0, alu_co};
               res_zero_d = alu_zero & ~alu_co;
               res_err_d  = 1'b0;
            end
            state_d = DONE;
         end
         MUL_LOOP: begin
            // Shift the 17-bit {carry, sum, multiplier} right by one each step.
            alu_opt  = OPT_ADD;
            alu_numa = acc_hi_q;
            alu_numb = acc_lo_q[0] ? a_q : 8'd0;
            nxt_hi   = {alu_co, alu_s[7:1]};
            nxt_lo   = {alu_s[0], acc_lo_q[7:1]};
            acc_hi_d = nxt_hi;
            acc_lo_d = nxt_lo;
            cnt_d    = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               res_lo_d   = nxt_lo;
               res_hi_d   = nxt_hi;
               res_zero_d = ({nxt_hi, nxt_lo} == 16'd0);
               res_err_d  = 1'b0;
               state_d    = DONE;
            end
         end
         DIV_LOOP: begin
            // acc_hi holds the partial remainder, acc_lo the dividend/quotient.
            alu_opt  = OPT_SUB;
            alu_numa = {acc_hi_q[6:0], acc_lo_q[7]};
            alu_numb = b_q;
            div_ok   = acc_hi_q[7] | ~alu_co;
            nxt_hi   = div_ok ? alu_s : alu_numa;
            nxt_lo   = {acc_lo_q[6:0], div_ok};
            acc_hi_d = nxt_hi;
            acc_lo_d = nxt_lo;
            cnt_d    = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               res_lo_d   = nxt_lo;
               res_hi_d   = nxt_hi;
               res_zero_d = ({nxt_hi, nxt_lo} == 16'd0);
               res_err_d  = 1'b0;
               state_d    = DONE;
            end
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_d = IDLE;
`ifdef ALU_SEQ_CNT_EN
               if (op_cnt_q != 16'hFFFF) op_cnt_d = op_cnt_q + 16'd1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         op_q       <= 2'd0;
         a_q        <= 8'd0;
         b_q        <= 8'd0;
         acc_hi_q   <= 8'd0;
         acc_lo_q   <= 8'd0;
         cnt_q      <= 3'd0;
         res_lo_q   <= 8'd0;
         res_hi_q   <= 8'd0;
         res_zero_q <= 1'b0;
         res_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         acc_hi_q   <= acc_hi_d;
         acc_lo_q   <= acc_lo_d;
         cnt_q      <= cnt_d;
         res_lo_q   <= res_lo_d;
         res_hi_q   <= res_hi_d;
         res_zero_q <= res_zero_d;
         res_err_q  <= res_err_d;
      end
   end

`ifdef ALU_SEQ_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) op_cnt_q <= 16'd0;
      else     op_cnt_q <= op_cnt_d;
   end
   assign op_cnt = op_cnt_q;
`endif

   assign res_lo   = res_lo_q;
   assign res_hi   = res_hi_q;
   assign res_zero = res_zero_q;
   assign res_err  = res_err_q;
   assign alu_ci   = 8'd0;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer with a behavioural ALU
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_a, cmd_b;
   logic       res_valid, res_ready;
   logic [7:0] res_lo, res_hi;
   logic       res_zero, res_err;
   logic [2:0] alu_opt;
   logic [7:0] alu_numa, alu_numb, alu_ci, alu_s;
   logic       alu_zero, alu_co;
`ifdef ALU_SEQ_CNT_EN
   logic [15:0] op_cnt;
`endif

   int tests = 0;
   int fails = 0;
   int lat;

   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_lo(res_lo), .res_hi(res_hi), .res_zero(res_zero), .res_err(res_err),
      .alu_opt(alu_opt), .alu_numa(alu_numa), .alu_numb(alu_numb), .alu_ci(alu_ci),
      .alu_s(alu_s), .alu_zero(alu_zero), .alu_co(alu_co)
`ifdef ALU_SEQ_CNT_EN
      , .op_cnt(op_cnt)
`endif
   );

   // Reference ALU: co is carry for ADD, borrow for SUB.
   always_comb begin
      case (alu_opt)
         3'd1:    {alu_co, alu_s} = {1'b0, alu_numa} + {1'b0, alu_numb};
         3'd2:    {alu_co, alu_s} = {1'b0, alu_numa} - {1'b0, alu_numb};
         default: {alu_co, alu_s} = 9'd0;
      endcase
      alu_zero = (alu_s == 8'd0);
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge; returns just after the negedge of the cycle after accept.
   task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
   endtask

   // lat is the cycle index (accept cycle = 0) at which res_valid is first seen.
   task automatic wait_res(output int l);
      l = 1;
      while (!res_valid && l < 20) begin
         @(negedge clk);
         l++;
      end
   endtask

   task automatic consume(input string tag);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check({tag, "_valid_drop"}, 16'(res_valid), 16'd0);
      check({tag, "_ready_back"}, 16'(cmd_ready), 16'd1);
   endtask

   task automatic run(input string tag, input logic [1:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] exp_res, input logic exp_zero,
                      input logic exp_err, input int exp_lat);
      int l;
      issue(op, a, b);
      wait_res(l);
      check({tag, "_lat"}, 16'(l), 16'(exp_lat));
      check({tag, "_res"}, {res_hi, res_lo}, exp_res);
      check({tag, "_zero"}, 16'(res_zero), 16'(exp_zero));
      check({tag, "_err"}, 16'(res_err), 16'(exp_err));
      check({tag, "_busy"}, 16'(cmd_ready), 16'd0);
      consume(tag);
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_a = 8'd0; cmd_b = 8'd0; res_ready = 1'b0;
      #3;
      check("rst_cmd_ready", 16'(cmd_ready), 16'd0);
      check("rst_res_valid", 16'(res_valid), 16'd0);
      check("rst_res", {res_hi, res_lo}, 16'd0);
      check("rst_flags", {14'd0, res_zero, res_err}, 16'd0);
      check("rst_alu_opt", 16'(alu_opt), 16'd0);
      check("rst_alu_ops", {alu_numa, alu_numb}, 16'd0);
      check("rst_alu_ci", 16'(alu_ci), 16'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("idle_ready", 16'(cmd_ready), 16'd1);

      run("add",   2'd0, 8'd200, 8'd100, 16'h012C, 1'b0, 1'b0, 2);
      run("sub",   2'd1, 8'd6,   8'd12,  16'h01FA, 1'b0, 1'b0, 2);
      run("sub0",  2'd1, 8'd12,  8'd12,  16'h0000, 1'b1, 1'b0, 2);
      run("mulff", 2'd2, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0, 9);
      run("mul0",  2'd2, 8'd0,   8'd77,  16'h0000, 1'b1, 1'b0, 9);
      run("div",   2'd3, 8'd200, 8'd7,   16'h041C, 1'b0, 1'b0, 9);
      run("div0",  2'd3, 8'd5,   8'd0,   16'h05FF, 1'b0, 1'b1, 2);

      // Backpressure: result held while a second command waits.
      issue(2'd2, 8'd13, 8'd11);
      wait_res(lat);
      check("bp_lat", 16'(lat), 16'd9);
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 8'd3; cmd_b = 8'd4;
      for (int i = 0; i < 3; i++) begin
         check("bp_res", {res_hi, res_lo}, 16'h008F);
         check("bp_valid", 16'(res_valid), 16'd1);
         check("bp_ready", 16'(cmd_ready), 16'd0);
         @(negedge clk);
      end
      check("bp_res_end", {res_hi, res_lo}, 16'h008F);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("bp_valid_drop", 16'(res_valid), 16'd0);
      check("bp_ready_back", 16'(cmd_ready), 16'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_res(lat);
      check("bp2_lat", 16'(lat), 16'd2);
      check("bp2_res", {res_hi, res_lo}, 16'h0007);
      consume("bp2");

      // Reset during the 4th MUL_LOOP cycle.
      issue(2'd2, 8'd13, 8'd11);
      repeat (3) @(negedge clk);
      check("mid_alu_busy", 16'(alu_opt), 16'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_ready", 16'(cmd_ready), 16'd0);
      check("mid_rst_valid", 16'(res_valid), 16'd0);
      check("mid_rst_res", {res_hi, res_lo}, 16'd0);
      check("mid_rst_alu_opt", 16'(alu_opt), 16'd0);
      check("mid_rst_alu_ops", {alu_numa, alu_numb}, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_idle", 16'(res_valid), 16'd0);
      run("add11", 2'd0, 8'd1, 8'd1, 16'h0002, 1'b0, 1'b0, 2);
`ifdef ALU_SEQ_CNT_EN
      check("op_cnt", op_cnt, 16'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-level controller in front of the 8-bit ALU (opt/numa/numb/ci -> s/zero/co).
- Accepts ADD, SUB, MUL and DIV commands over a valid/ready handshake and drives the ALU cycle by cycle.
- MUL is 8x8->16 shift-add using ALU add; DIV is 8/8 restoring division using ALU subtract.
- Returns a 16-bit result plus flags over a valid/ready handshake; sits between the calculator control logic and the ALU.

Parameters:
OPT_NOP, 3'd0, ALU opt value driven when idle
OPT_ADD, 3'd1, ALU opt for numa+numb; co = carry out
OPT_SUB, 3'd2, ALU opt for numa-numb; co = 1 when borrow (numa<numb)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  0=ADD 1=SUB 2=MUL 3=DIV
cmd_a  in  8  operand A / dividend / multiplicand
cmd_b  in  8  operand B / divisor / multiplier
res_valid  out  1  result available
res_ready  in  1  result consumed when valid&ready
res_lo  out  8  ADD/SUB: s; MUL: product[7:0]; DIV: quotient
res_hi  out  8  ADD/SUB: {7'b0,co}; MUL: product[15:8]; DIV: remainder
res_zero  out  1  {res_hi,res_lo}==0
res_err  out  1  DIV by zero
alu_opt  out  3  to ALU opt
alu_numa  out  8  to ALU numa
alu_numb  out  8  to ALU numb
alu_ci  out  8  to ALU ci; always 0
alu_s  in  8  ALU result, combinational
alu_zero  in  1  ALU zero flag (unused internally beyond ADD/SUB)
alu_co  in  1  ALU carry/borrow

Behaviour:
- Reset (async, rst=1): state IDLE; cmd_ready=0 while rst high; res_valid=0; res_lo=res_hi=0; res_zero=0; res_err=0; alu_opt=OPT_NOP; alu_numa=alu_numb=alu_ci=0; iteration counter 0; any in-flight command dropped.
- States: IDLE, EXEC, MUL_LOOP, DIV_LOOP, DONE.
- IDLE: cmd_ready=1. On accept, latch a, b, op. ADD/SUB or DIV with b==0 -> EXEC. MUL -> MUL_LOOP with acc_hi=0, acc_lo=b, cnt=0. DIV with b!=0 -> DIV_LOOP with rem=0, q=a, cnt=0.
- EXEC: drive opt=ADD/SUB with numa=a, numb=b. Capture s and co into res_lo/res_hi. DIV-by-zero: res_lo=8'hFF, res_hi=a, res_err=1, ALU held at NOP. Next state DONE.
- MUL_LOOP: drive OPT_ADD, numa=acc_hi, numb = acc_lo[0] ? a : 0. Update {acc_hi,acc_lo} <= {alu_co, alu_s, acc_lo} >> 1 (17-bit shift, low bit dropped). cnt++. After the 8th iteration (cnt==7), go to DONE with result {acc_hi,acc_lo}.
- DIV_LOOP: p = {rem, q[7]} (9 bits). Drive OPT_SUB, numa=p[7:0], numb=b. ok = p[8] | ~alu_co. If ok: rem<=alu_s, else rem<=p[7:0]. q<={q[6:0], ok}. 8 iterations, then DONE with res_lo=q, res_hi=rem.
- DONE: res_valid=1. Outputs held stable until res_ready. On handshake, go to IDLE and drop res_valid next cycle. cmd_ready=0 in every non-IDLE state (no overlap).
- ALU outside EXEC/loops: opt=OPT_NOP, numa=numb=0.
- Latency (accept edge = T): ADD/SUB/DIV0 res_valid at T+2; MUL/DIV res_valid at T+9.
- res_zero and res_err are registered with the result. res_err=0 for every non-DIV0 op.
- cmd_op and operands are ignored except at accept.

Optional Feature:
ALU_SEQ_CNT_EN: adds output op_cnt (16 bits), reset 0, incremented on every res handshake, saturating at 16'hFFFF. Without the macro the port and the counter do not exist; behaviour is otherwise identical.

Test Plan:
- ADD a=200, b=100 -> res_lo=0x2C, res_hi=0x01, res_zero=0; res_valid 2 cycles after accept.
- SUB a=6, b=12 -> res_lo=0xFA, res_hi=0x01. SUB a=12, b=12 -> res_lo=0, res_hi=0, res_zero=1.
- MUL a=255, b=255 -> {hi,lo}=0xFE01 at T+9. MUL a=0, b=77 -> 0x0000 with res_zero=1.
- DIV a=200, b=7 -> res_lo=0x1C, res_hi=0x04. DIV a=5, b=0 -> res_lo=0xFF, res_hi=0x05, res_err=1 at T+2.
- Backpressure: hold res_ready=0 for 3 cycles after MUL 13*11 -> result 0x008F stays stable, cmd_ready=0, a second cmd_valid is not accepted until after the handshake.
- Assert rst at the 4th MUL_LOOP cycle -> all outputs return to reset values immediately; the next ADD 1+1 returns 0x0002.
